// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameters for the run sequencer.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2,
        FINISH   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ST_NONE    = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_WDOG    = 3'd4
    } status_e;

    localparam int unsigned DEF_RST_CYCLES     = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;
    localparam int unsigned DEF_DRAIN_CYCLES   = 4;
    localparam int unsigned DEF_CNT_W          = 32;
    localparam int unsigned DEF_WDOG_CYCLES    = 1024;

endpackage

// File: rtl/run_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
module sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc,
    output logic [W-1:0] cnt,
    output logic         hit
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   cnt <= '0;
        else if (clr)               cnt <= '0;
        else if (en && cnt != '1)   cnt <= cnt + 1'b1;
    end

    assign hit = (cnt == tc);

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: reset hold, run with done/timeout, drain, finish.
// Optional liveness watchdog enabled by defining RUN_CTRL_WDOG_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned WDOG_CYCLES    = DEF_WDOG_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             dut_done,
    input  logic             dut_pass,
    input  logic             dut_heartbeat,
    output logic             dut_rst,
    output logic             running,
    output logic             finished,
    output status_e          status,
    output logic [CNT_W-1:0] cycles
);

    localparam int unsigned HOLD_W  = $clog2(RST_CYCLES + 1);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 2);
    localparam int unsigned DRAIN_TC = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;

    state_e             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               hold_hit, run_hit, drain_hit, wdog_hit, end_run;

    assign end_run = dut_done || run_hit || wdog_hit;

    sat_cnt #(.W(HOLD_W)) u_hold (
        .clk, .rst,
        .clr (state != RST_HOLD),
        .en  (state == RST_HOLD),
        .tc  (HOLD_W'(RST_CYCLES - 1)),
        .cnt (hold_cnt),
        .hit (hold_hit)
    );

    // The run counter holds on the exit edge so cycles reports the count seen at done/timeout.
    sat_cnt #(.W(CNT_W)) u_run (
        .clk, .rst,
        .clr (state == FINISH && restart),
        .en  (state == RUN && !end_run),
        .tc  (CNT_W'(TIMEOUT_CYCLES - 1)),
        .cnt (cycles),
        .hit (run_hit)
    );

    sat_cnt #(.W(DRAIN_W)) u_drain (
        .clk, .rst,
        .clr (state != DRAIN),
        .en  (state == DRAIN),
        .tc  (DRAIN_W'(DRAIN_TC)),
        .cnt (drain_cnt),
        .hit (drain_hit)
    );

`ifdef RUN_CTRL_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_tc;

    sat_cnt #(.W(WDOG_W)) u_wdog (
        .clk, .rst,
        .clr (state != RUN || dut_heartbeat),
        .en  (state == RUN),
        .tc  (WDOG_W'(WDOG_CYCLES - 1)),
        .cnt (wdog_cnt),
        .hit (wdog_tc)
    );
    // A heartbeat landing on the terminal count still counts as alive.
    assign wdog_hit = wdog_tc && !dut_heartbeat;

    logic unused;
    assign unused = ^{hold_cnt, drain_cnt, wdog_cnt};
`else
    assign wdog_hit = 1'b0;

    logic unused;
    assign unused = ^{hold_cnt, drain_cnt, dut_heartbeat};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RST_HOLD;
            dut_rst  <= 1'b1;
            running  <= 1'b0;
            finished <= 1'b0;
            status   <= ST_NONE;
        end else begin
            case (state)
                RST_HOLD: if (hold_hit) begin
                    state   <= RUN;
                    dut_rst <= 1'b0;
                    running <= 1'b1;
                end
                RUN: if (end_run) begin
                    running <= 1'b0;
                    if (dut_done)     status <= dut_pass ? ST_PASS : ST_FAIL;
                    else if (run_hit) status <= ST_TIMEOUT;
                    else              status <= ST_WDOG;
                    if (DRAIN_CYCLES == 0) begin
                        state    <= FINISH;
                        finished <= 1'b1;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: if (drain_hit) begin
                    state    <= FINISH;
                    finished <= 1'b1;
                end
                FINISH: if (restart) begin
                    state    <= RST_HOLD;
                    dut_rst  <= 1'b1;
                    finished <= 1'b0;
                    status   <= ST_NONE;
                end
                default: state <= RST_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed vector bench for run_ctrl (RST=4, TIMEOUT=50, DRAIN=2, WDOG=8).
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        restart = 1'b0, dut_done = 1'b0, dut_pass = 1'b0, dut_heartbeat = 1'b0;
    logic        dut_rst, running, finished;
    status_e     status;
    logic [31:0] cycles;

    int total = 0;
    int bad = 0;

    run_ctrl #(
        .RST_CYCLES(4), .TIMEOUT_CYCLES(50), .DRAIN_CYCLES(2), .CNT_W(32), .WDOG_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart), .dut_done(dut_done), .dut_pass(dut_pass),
        .dut_heartbeat(dut_heartbeat), .dut_rst(dut_rst), .running(running),
        .finished(finished), .status(status), .cycles(cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       n;
        logic     rst, restart, done, pass;
        logic     drst, run, fin;
        status_e  st;
        int       cyc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int n, logic r, logic rs, logic d, logic p,
                                logic edr, logic er, logic ef, status_e es, int ec);
        vec_t v;
        v.n = n; v.rst = r; v.restart = rs; v.done = d; v.pass = p;
        v.drst = edr; v.run = er; v.fin = ef; v.st = es; v.cyc = ec;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic edr, input logic er, input logic ef,
                           input status_e es, input int ec);
        chk({tag, ".dut_rst"}, int'(dut_rst), int'(edr));
        chk({tag, ".running"}, int'(running), int'(er));
        chk({tag, ".finished"}, int'(finished), int'(ef));
        chk({tag, ".status"}, int'(status), int'(es));
        chk({tag, ".cycles"}, int'(cycles), ec);
    endtask

    task automatic run_vec(input int i);
        for (int k = 0; k < tbl[i].n; k++) begin
            @(negedge clk);
            rst = tbl[i].rst; restart = tbl[i].restart;
            dut_done = tbl[i].done; dut_pass = tbl[i].pass; dut_heartbeat = 1'b0;
            @(posedge clk);
            #1;
        end
        chk_all($sformatf("vec%0d", i), tbl[i].drst, tbl[i].run, tbl[i].fin, tbl[i].st, tbl[i].cyc);
    endtask

    task automatic cyc(input logic hb);
        @(negedge clk);
        restart = 1'b0; dut_done = 1'b0; dut_pass = 1'b0; dut_heartbeat = hb;
        @(posedge clk);
        #1;
    endtask

    int part_a, edges, exp_edges, exp_cyc;
    status_e exp_st;

    initial begin
        // reset, hold, pass at cycles=10, drain
        add(1, 0,0,0,0, 1,0,0, ST_NONE, 0);
        add(3, 1,0,0,0, 1,0,0, ST_NONE, 0);
        add(1, 1,0,0,0, 0,1,0, ST_NONE, 0);
        add(10,1,0,0,0, 0,1,0, ST_NONE, 10);
        add(1, 1,0,1,1, 0,0,0, ST_PASS, 10);
        add(1, 1,0,0,0, 0,0,0, ST_PASS, 10);
        add(1, 1,0,0,0, 0,0,1, ST_PASS, 10);
        // finish holds, restart repeats the hold
        add(2, 1,0,0,0, 0,0,1, ST_PASS, 10);
        add(1, 1,1,0,0, 1,0,0, ST_NONE, 0);
        add(3, 1,0,0,0, 1,0,0, ST_NONE, 0);
        add(1, 1,0,0,0, 0,1,0, ST_NONE, 0);
        // restart in RUN ignored; FAIL; done during drain ignored
        add(5, 1,0,0,0, 0,1,0, ST_NONE, 5);
        add(1, 1,1,0,0, 0,1,0, ST_NONE, 6);
        add(1, 1,0,1,0, 0,0,0, ST_FAIL, 6);
        add(1, 1,0,1,1, 0,0,0, ST_FAIL, 6);
        add(1, 1,0,0,0, 0,0,1, ST_FAIL, 6);
        // timeout
        add(1, 1,1,0,0, 1,0,0, ST_NONE, 0);
        add(4, 1,0,0,0, 0,1,0, ST_NONE, 0);
        add(49,1,0,0,0, 0,1,0, ST_NONE, 49);
        add(1, 1,0,0,0, 0,0,0, ST_TIMEOUT, 49);
        add(2, 1,0,0,0, 0,0,1, ST_TIMEOUT, 49);
        // done coinciding with timeout wins
        add(1, 1,1,0,0, 1,0,0, ST_NONE, 0);
        add(4, 1,0,0,0, 0,1,0, ST_NONE, 0);
        add(49,1,0,0,0, 0,1,0, ST_NONE, 49);
        add(1, 1,0,1,1, 0,0,0, ST_PASS, 49);
        add(2, 1,0,0,0, 0,0,1, ST_PASS, 49);
        // run to cycles=20 before async reset
        add(1, 1,1,0,0, 1,0,0, ST_NONE, 0);
        add(4, 1,0,0,0, 0,1,0, ST_NONE, 0);
        add(20,1,0,0,0, 0,1,0, ST_NONE, 20);
        part_a = tbl.size();
        // hold repeats after release
        add(3, 1,0,0,0, 1,0,0, ST_NONE, 0);
        add(1, 1,0,0,0, 0,1,0, ST_NONE, 0);

        for (int i = 0; i < part_a; i++) run_vec(i);

        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_all("async_rst", 1'b1, 1'b0, 1'b0, ST_NONE, 0);

        for (int i = part_a; i < tbl.size(); i++) run_vec(i);

        // heartbeat every 5 cycles, then silence
        for (int g = 0; g < 4; g++) begin
            cyc(1'b1);
            repeat (4) cyc(1'b0);
        end
        chk("hb.running", int'(running), 1);
        chk("hb.cycles", int'(cycles), 20);

`ifdef RUN_CTRL_WDOG_EN
        exp_edges = 4;  exp_st = ST_WDOG;    exp_cyc = 23;
`else
        exp_edges = 30; exp_st = ST_TIMEOUT; exp_cyc = 49;
`endif
        edges = 0;
        while (running && edges < 60) begin
            cyc(1'b0);
            edges++;
        end
        chk("silence.edges", edges, exp_edges);
        chk("silence.status", int'(status), int'(exp_st));
        chk("silence.cycles", int'(cycles), exp_cyc);
        repeat (2) cyc(1'b0);
        chk("silence.finished", int'(finished), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
